apb_master_bridge: RTL and testbench

Core-side request/grant/rvalid to APB initiator bridge. It is the master end of the peripheral APB bus. The bridge accepts one core data request at a time and runs a full APB SETUP/ACCESS transfer toward the peripheral interconnect (UART, GPIO, SPI, timer and so on). It returns read data or an error to the core through a one-cycle rvalid pulse. A PREADY timeout keeps a hung slave from stalling the core.

---
 rtl/apb_master_bridge.sv | 102 ++++++++++
 tb/tb_apb_master_bridge.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// Core request/grant/rvalid to APB initiator bridge.
// Runs one SETUP/ACCESS transfer per granted request. A PREADY timeout stops a hung slave from stalling the core.
module apb_master_bridge #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      data_req_i,
    output logic                      data_gnt_o,
    input  logic [31:0]               data_addr_i,
    input  logic                      data_we_i,
    input  logic [3:0]                data_be_i,
    input  logic [APB_DATA_WIDTH-1:0] data_wdata_i,
    output logic                      data_rvalid_o,
    output logic [APB_DATA_WIDTH-1:0] data_rdata_o,
    output logic                      data_err_o,
    output logic [APB_ADDR_WIDTH-1:0] paddr,
    output logic [APB_DATA_WIDTH-1:0] pwdata,
    output logic                      pwrite,
    output logic                      psel,
    output logic                      penable,
    input  logic [APB_DATA_WIDTH-1:0] prdata,
    input  logic                      pready,
    input  logic                      pslverr,
    output logic                      busy_o
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    // The counter only has to reach TIMEOUT_CYCLES-1: the abort happens on that cycle.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    logic [1:0]       state;
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_hit;
    logic             partial_write;

    assign timeout_hit   = (TIMEOUT_CYCLES != 0) && (wait_cnt == CNT_LAST);
    assign partial_write = data_we_i && (data_be_i != 4'hF);

    assign data_gnt_o    = (state == IDLE) && data_req_i;
    assign psel          = (state == SETUP) || (state == ACCESS);
    assign penable       = (state == ACCESS);
    assign data_rvalid_o = (state == RESP);
    assign busy_o        = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            paddr        <= '0;
            pwdata       <= '0;
            pwrite       <= 1'b0;
            data_rdata_o <= '0;
            data_err_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (data_req_i) begin
                        // Peripherals are word registers, so sub-word writes are refused without touching the bus.
                        if (partial_write) begin
                            data_rdata_o <= '0;
                            data_err_o   <= 1'b1;
                            state        <= RESP;
                        end else begin
                            paddr    <= APB_ADDR_WIDTH'(data_addr_i & 32'hFFFF_FFFC);
                            pwrite   <= data_we_i;
                            pwdata   <= data_we_i ? data_wdata_i : '0;
                            wait_cnt <= '0;
                            state    <= SETUP;
                        end
                    end
                end
                SETUP: state <= ACCESS;
                ACCESS: begin
                    // A late pready on the limit cycle still completes the transfer.
                    if (pready) begin
                        data_rdata_o <= pwrite ? '0 : prdata;
                        data_err_o   <= pslverr;
                        state        <= RESP;
                    end else if (timeout_hit) begin
                        data_rdata_o <= '0;
                        data_err_o   <= 1'b1;
                        state        <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed scenarios plus random transfers, with a transaction-level timing model.
module tb_apb_master_bridge;

    localparam int TO = 4;

    logic        clk;
    logic        rst_n;
    logic        data_req_i;
    logic        data_gnt_o;
    logic [31:0] data_addr_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_wdata_i;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        busy_o;

    int n_vec = 0;
    int n_err = 0;
    time t_gnt;

    apb_master_bridge #(
        .APB_ADDR_WIDTH(32),
        .APB_DATA_WIDTH(32),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .data_req_i(data_req_i), .data_gnt_o(data_gnt_o),
        .data_addr_i(data_addr_i), .data_we_i(data_we_i),
        .data_be_i(data_be_i), .data_wdata_i(data_wdata_i),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
        .data_err_o(data_err_o),
        .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
        .psel(psel), .penable(penable),
        .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One core transfer. waits = number of ACCESS cycles with pready low before it rises.
    task automatic run_txn(input logic [31:0] addr, input logic we, input logic [3:0] be,
                           input logic [31:0] wdata, input int waits,
                           input logic [31:0] prd, input logic perr);
        logic        bad;
        int          nacc;
        int          rv;
        logic [31:0] e_rd;
        logic        e_err;
        logic        e_psel;
        bad = we && (be != 4'hF);
        if (bad) begin
            nacc = 0; rv = 1; e_rd = 32'h0; e_err = 1'b1;
        end else if (waits >= TO) begin
            nacc = TO; rv = TO + 2; e_rd = 32'h0; e_err = 1'b1;
        end else begin
            nacc = waits + 1; rv = waits + 3;
            e_rd = we ? 32'h0 : prd; e_err = perr;
        end

        @(negedge clk);
        data_req_i = 1'b1; data_addr_i = addr; data_we_i = we;
        data_be_i = be; data_wdata_i = wdata; pready = 1'b0;
        #1;
        t_gnt = $time;
        chk("gnt_c0", {31'b0, data_gnt_o}, 32'd1);
        chk("busy_c0", {31'b0, busy_o}, 32'd0);
        chk("psel_c0", {31'b0, psel}, 32'd0);

        for (int c = 1; c <= rv; c++) begin
            @(posedge clk);
            #1;
            data_addr_i  = $urandom;
            data_we_i    = 1'($urandom);
            data_be_i    = 4'($urandom);
            data_wdata_i = $urandom;
            if (c == 1) pready = 1'($urandom);
            else        pready = (c == waits + 2);
            prdata  = pready ? prd : $urandom;
            pslverr = pready ? perr : 1'($urandom);
            @(negedge clk);
            e_psel = !bad && (c <= nacc + 1);
            chk("gnt", {31'b0, data_gnt_o}, 32'd0);
            chk("busy", {31'b0, busy_o}, 32'd1);
            chk("psel", {31'b0, psel}, {31'b0, e_psel});
            chk("penable", {31'b0, penable}, {31'b0, (!bad && c >= 2 && c <= nacc + 1)});
            chk("rvalid", {31'b0, data_rvalid_o}, {31'b0, (c == rv)});
            if (e_psel) begin
                chk("paddr", paddr, addr & 32'hFFFF_FFFC);
                chk("pwrite", {31'b0, pwrite}, {31'b0, we});
                chk("pwdata", pwdata, we ? wdata : 32'h0);
            end
            if (c == rv) begin
                chk("rdata", data_rdata_o, e_rd);
                chk("err", {31'b0, data_err_o}, {31'b0, e_err});
            end
        end
        data_req_i = 1'b0;
        pready = 1'b0;
    endtask

    initial begin
        time tg1;
        rst_n = 1'b0; data_req_i = 1'b0; data_addr_i = '0; data_we_i = 1'b0;
        data_be_i = '0; data_wdata_i = '0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
        data_req_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_psel", {31'b0, psel}, 32'd0);
        chk("rst_penable", {31'b0, penable}, 32'd0);
        chk("rst_rvalid", {31'b0, data_rvalid_o}, 32'd0);
        chk("rst_busy", {31'b0, busy_o}, 32'd0);
        chk("rst_paddr", paddr, 32'h0);
        chk("rst_pwdata", pwdata, 32'h0);
        chk("rst_pwrite", {31'b0, pwrite}, 32'd0);
        chk("rst_rdata", data_rdata_o, 32'h0);
        chk("rst_err", {31'b0, data_err_o}, 32'd0);
        data_req_i = 1'b0;
        rst_n = 1'b1;

        // Directed scenarios
        run_txn(32'h1A10_1004, 1'b0, 4'hF, 32'h0, 0, 32'hDEAD_BEEF, 1'b0);
        run_txn(32'h1A10_2008, 1'b1, 4'hF, 32'h1234_5678, 3, 32'hFFFF_FFFF, 1'b0);
        run_txn(32'h1A10_3003, 1'b0, 4'hF, 32'h0, 1, 32'h0000_0055, 1'b1);
        run_txn(32'h1A10_4000, 1'b1, 4'b0011, 32'hCAFE_F00D, 0, 32'h0, 1'b0);
        run_txn(32'h1A10_5010, 1'b0, 4'hF, 32'h0, 10, 32'h1111_2222, 1'b0);
        run_txn(32'h1A10_5014, 1'b0, 4'hF, 32'h0, 3, 32'h3333_4444, 1'b0);
        run_txn(32'h1A10_5018, 1'b1, 4'hF, 32'hA5A5_5A5A, 4, 32'h0, 1'b0);

        // Reset while in ACCESS
        @(negedge clk);
        data_req_i = 1'b1; data_addr_i = 32'h1A10_6000; data_we_i = 1'b0;
        data_be_i = 4'hF; pready = 1'b0;
        @(posedge clk); #1 data_req_i = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_penable", {31'b0, penable}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_psel", {31'b0, psel}, 32'd0);
        chk("async_penable", {31'b0, penable}, 32'd0);
        chk("async_busy", {31'b0, busy_o}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_rvalid", {31'b0, data_rvalid_o}, 32'd0);
            chk("post_rst_busy", {31'b0, busy_o}, 32'd0);
        end

        // Back-to-back reads with the request held high
        run_txn(32'h1A10_7000, 1'b0, 4'hF, 32'h0, 0, 32'h0BAD_CAFE, 1'b0);
        tg1 = t_gnt;
        run_txn(32'h1A10_7004, 1'b0, 4'hF, 32'h0, 0, 32'h0123_4567, 1'b0);
        chk("gnt_spacing", 32'(t_gnt - tg1), 32'd40);

        // Random transfers
        for (int k = 0; k < 40; k++) begin
            logic       rwe;
            logic [3:0] rbe;
            rwe = 1'($urandom);
            rbe = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            run_txn($urandom, rwe, rbe, $urandom, $urandom_range(0, 6),
                    $urandom, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
